// File: rtl/reg_rr_arbiter_pkg.sv
// rtl/reg_rr_arbiter_pkg.sv - shared types, constants and helpers for reg_rr_arbiter
package reg_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int WAIT_CNT_W = 16;
  localparam int MAX_REQ    = 8;
  localparam int MAX_IDX_W  = 3;

  // Widest one-hot vector; callers truncate to their own requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_rr_arbiter_pick.sv
// rtl/reg_rr_arbiter_pick.sv - combinational rotate-priority picker (module rr_pick)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   pick,
  output logic               any_req
);

  // Scan from the farthest candidate back to ptr so the lowest rotated
  // distance from ptr is the last (winning) assignment.
  always_comb begin
    logic [IDX_W-1:0] cand;
    pick    = '0;
    cand    = '0;
    any_req = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (req[cand]) pick = cand;
    end
  end

endmodule

// File: rtl/reg_rr_arbiter.sv
// rtl/reg_rr_arbiter.sv - round-robin owner arbiter and write sequencer for one shared register (optional REG_RR_ARBITER_STATS_EN)
module reg_rr_arbiter
  import reg_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  input  logic                      clear,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [IDX_W-1:0]          owner,
  output logic                      wr_ack,
  output logic                      busy,
  output logic [DATA_W-1:0]         q
`ifdef REG_RR_ARBITER_STATS_EN
  ,
  output logic [WAIT_CNT_W-1:0]     wait_cnt
`endif
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_t              state, state_d;
  logic [NUM_REQ-1:0]  gnt_d;
  logic [IDX_W-1:0]    owner_d, ptr, ptr_d, pick, owner_inc;
  logic [HOLD_W-1:0]   hold_cnt, hold_d;
  logic                any_req;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .pick    (pick),
    .any_req (any_req)
  );

  assign busy      = (state == OWN);
  assign wr_ack    = (state == OWN) & req[owner] & ~reset;
  assign owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // Next-state: grant in IDLE, count writes and release in OWN.
  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    owner_d = owner;
    ptr_d   = ptr;
    hold_d  = hold_cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_d = OWN;
          gnt_d   = NUM_REQ'(onehot(MAX_IDX_W'(pick)));
          owner_d = pick;
          hold_d  = '0;
        end
      end
      OWN: begin
        if (req[owner]) hold_d = hold_cnt + 1'b1;
        if (!req[owner] || hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = owner_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      owner    <= owner_d;
      ptr      <= ptr_d;
      hold_cnt <= hold_d;
    end
  end

  // Shared register: clear wins over the owner's write.
  always_ff @(posedge clk) begin
    if (reset || clear) q <= '0;
    else if (wr_ack)    q <= wr_data[owner*DATA_W +: DATA_W];
  end

`ifdef REG_RR_ARBITER_STATS_EN
  // Saturating count of cycles where someone else is kept waiting.
  always_ff @(posedge clk) begin
    if (reset) wait_cnt <= '0;
    else if (state == OWN && (req & ~gnt) != '0 && wait_cnt != '1)
      wait_cnt <= wait_cnt + 1'b1;
  end
`else
  // No waiting statistics in this build.
`endif

endmodule
